gpio_trigger_sequencer: RTL and testbench

//  Generates the programmable start-trigger pulse train that feeds gpio_wrapper.gpio_start_trigger_i.

---
 rtl/gpio_seq_pkg.sv | 22 ++
 rtl/gpio_seq_dncnt.sv | 30 +++
 rtl/gpio_trigger_sequencer.sv | 147 ++++++++++++++
 tb/tb_gpio_trigger_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/gpio_seq_pkg.sv
// Shared types and helpers for the GPIO start-trigger sequencer.
package gpio_seq_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int REP_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // A single pulse never enters LOW, so it needs no gap after the high phase.
    function automatic logic cfg_valid(input logic width_nz,
                                       input logic width_lt_period,
                                       input logic single_pulse);
        return width_nz && (single_pulse || width_lt_period);
    endfunction

endpackage

// File: rtl/gpio_seq_dncnt.sv
// Loadable down-counter that parks at zero instead of wrapping.
module gpio_seq_dncnt #(
    parameter int W = 32
) (
    input  logic         sys_clk_i,
    input  logic         rst_n_i,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_r;

    // count register: load wins over decrement
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= value;
        end else if (en && (count_r != '0)) begin
            count_r <= count_r - W'(1);
        end
    end

    assign count = count_r;
    assign zero  = (count_r == '0);

endmodule

// File: rtl/gpio_trigger_sequencer.sv
// Programmable delay + pulse-train generator driving the GPIO start trigger.
module gpio_trigger_sequencer
    import gpio_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             sys_clk_i,
    input  logic             rst_n_i,
    input  logic [CNT_W-1:0] cfg_delay_i,
    input  logic [CNT_W-1:0] cfg_width_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [REP_W-1:0] cfg_repeat_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             trig_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             cfg_err_o,
    output logic [REP_W-1:0] pulse_cnt_o
);

    seq_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] width_r, period_r;
    logic [REP_W-1:0] repeat_r, pulse_cnt_r, pulse_inc_s, pulse_eff_s;
    logic             trig_r, busy_r, done_r, aborted_r, cfg_err_r;
    logic             accept_s, cfg_ok_s, rise_s, last_s, abort_run_s;
    logic             cnt_load_s, cnt_en_s, cnt_zero_s;
    logic [CNT_W-1:0] cnt_val_s, cnt_q_s;

    assign accept_s    = (state_r == ST_IDLE) && start_i && !abort_i;
    assign abort_run_s = (state_r != ST_IDLE) && abort_i;
    assign cfg_ok_s    = cfg_valid(cfg_width_i != '0, cfg_width_i < cfg_period_i,
                                   cfg_repeat_i == REP_W'(1));
    // outputs lag the state by one cycle, so the first HIGH cycle is the rising one
    assign rise_s      = (state_r == ST_HIGH) && !trig_r;
    assign pulse_inc_s = (pulse_cnt_r == '1) ? pulse_cnt_r : pulse_cnt_r + REP_W'(1);
    assign pulse_eff_s = rise_s ? pulse_inc_s : pulse_cnt_r;
    assign last_s      = (repeat_r != '0) && (pulse_eff_s == repeat_r);

    gpio_seq_dncnt #(.W(CNT_W)) u_dncnt (
        .sys_clk_i (sys_clk_i),
        .rst_n_i   (rst_n_i),
        .load      (cnt_load_s),
        .en        (cnt_en_s),
        .value     (cnt_val_s),
        .count     (cnt_q_s),
        .zero      (cnt_zero_s)
    );

    // next-state and counter control
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cnt_en_s    = 1'b0;
        cnt_val_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && cfg_ok_s) begin
                    cnt_load_s = 1'b1;
                    if (cfg_delay_i != '0) begin
                        state_nxt_s = ST_DELAY;
                        cnt_val_s   = cfg_delay_i - CNT_W'(1);
                    end else begin
                        state_nxt_s = ST_HIGH;
                        cnt_val_s   = cfg_width_i - CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DELAY, ST_LOW: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_HIGH;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = width_r - CNT_W'(1);
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_HIGH: begin
                if (!cnt_zero_s) begin
                    cnt_en_s = 1'b1;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOW;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = period_r - width_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (abort_run_s) begin
            state_nxt_s = ST_IDLE;
            cnt_load_s  = 1'b0;
            cnt_en_s    = 1'b0;
        end else begin
            cnt_en_s = cnt_en_s;
        end
    end

    // state, shadow config, pulse counter and registered outputs
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            width_r     <= '0;
            period_r    <= '0;
            repeat_r    <= '0;
            pulse_cnt_r <= '0;
            trig_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            trig_r    <= (state_r == ST_HIGH) && !abort_i;
            busy_r    <= (state_r != ST_IDLE) && !abort_i;
            done_r    <= (state_r == ST_DONE) && !abort_i;
            aborted_r <= abort_run_s;
            cfg_err_r <= accept_s && !cfg_ok_s;
            if (accept_s && cfg_ok_s) begin
                width_r     <= cfg_width_i;
                period_r    <= cfg_period_i;
                repeat_r    <= cfg_repeat_i;
                pulse_cnt_r <= '0;
            end else if (rise_s && !abort_i) begin
                pulse_cnt_r <= pulse_inc_s;
            end
        end
    end

    assign trig_o      = trig_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign aborted_o   = aborted_r;
    assign cfg_err_o   = cfg_err_r;
    assign pulse_cnt_o = pulse_cnt_r;

endmodule

// File: tb/tb_gpio_trigger_sequencer.sv
// Directed bench for gpio_trigger_sequencer; bit i of each capture vector is the output after edge i.
module tb_gpio_trigger_sequencer;

    logic        sys_clk_s = 1'b0;
    logic        rst_n_s;
    logic [31:0] cfg_delay_s, cfg_width_s, cfg_period_s;
    logic [15:0] cfg_repeat_s;
    logic        start_s, abort_s;
    logic        trig_s, busy_s, done_s, aborted_s, cfg_err_s;
    logic [15:0] pulse_cnt_s;

    logic [31:0] trig_v, busy_v, done_v, err_v, abt_v;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 sys_clk_s = ~sys_clk_s;

    gpio_trigger_sequencer dut (
        .sys_clk_i   (sys_clk_s),
        .rst_n_i     (rst_n_s),
        .cfg_delay_i (cfg_delay_s),
        .cfg_width_i (cfg_width_s),
        .cfg_period_i(cfg_period_s),
        .cfg_repeat_i(cfg_repeat_s),
        .start_i     (start_s),
        .abort_i     (abort_s),
        .trig_o      (trig_s),
        .busy_o      (busy_s),
        .done_o      (done_s),
        .aborted_o   (aborted_s),
        .cfg_err_o   (cfg_err_s),
        .pulse_cnt_o (pulse_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge sys_clk_s);
        #1;
    endtask

    task automatic set_cfg(input int d, input int w, input int p, input int r);
        cfg_delay_s  = 32'(d);
        cfg_width_s  = 32'(w);
        cfg_period_s = 32'(p);
        cfg_repeat_s = 16'(r);
    endtask

    // Pulse start (unless do_start is 0) and record outputs for n edges.
    task automatic run_cap(input int n, input bit do_start, input int restart_at);
        trig_v = '0; busy_v = '0; done_v = '0; err_v = '0; abt_v = '0;
        start_s = do_start;
        for (int i = 0; i < n; i++) begin
            tick();
            start_s = (i + 1 == restart_at);
            if (i + 1 == restart_at) set_cfg(0, 1, 2, 1);
            trig_v[i] = trig_s;
            busy_v[i] = busy_s;
            done_v[i] = done_s;
            err_v[i]  = cfg_err_s;
            abt_v[i]  = aborted_s;
        end
        start_s = 1'b0;
    endtask

    initial begin
        rst_n_s = 1'b0; start_s = 1'b0; abort_s = 1'b0;
        set_cfg(0, 0, 0, 0);
        #12;
        chk("rst_outputs", {26'd0, trig_s, busy_s, done_s, aborted_s, cfg_err_s, 1'b0}, 32'd0);
        chk("rst_pulse_cnt", {16'd0, pulse_cnt_s}, 32'd0);
        @(negedge sys_clk_s); rst_n_s = 1'b1;

        // 1: delay 3, width 2, period 5, three pulses
        set_cfg(3, 2, 5, 3);
        run_cap(20, 1'b1, -1);
        chk("s1_trig", trig_v, 32'h0000_C630);
        chk("s1_busy", busy_v, 32'h0001_FFFE);
        chk("s1_done", done_v, 32'h0001_0000);
        chk("s1_cnt", {16'd0, pulse_cnt_s}, 32'd3);

        // 2: single one-cycle pulse with no delay
        set_cfg(0, 1, 2, 1);
        run_cap(6, 1'b1, -1);
        chk("s2_trig", trig_v, 32'h2);
        chk("s2_done", done_v, 32'h4);
        chk("s2_busy", busy_v, 32'h6);
        chk("s2_cnt", {16'd0, pulse_cnt_s}, 32'd1);

        // 3: width == period with repeat 2 is rejected
        set_cfg(0, 4, 4, 2);
        run_cap(6, 1'b1, -1);
        chk("s3_err", err_v, 32'h1);
        chk("s3_busy", busy_v, 32'h0);
        chk("s3_trig", trig_v, 32'h0);
        set_cfg(0, 0, 9, 1);
        run_cap(3, 1'b1, -1);
        chk("s3_zero_width_err", err_v, 32'h1);

        // 4: continuous mode, abort after the seventh pulse
        set_cfg(0, 1, 3, 0);
        run_cap(20, 1'b1, -1);
        chk("s4_trig", trig_v, 32'h0009_2492);
        chk("s4_cnt7", {16'd0, pulse_cnt_s}, 32'd7);
        abort_s = 1'b1;
        run_cap(6, 1'b0, -1);
        abort_s = 1'b0;
        chk("s4_abt", abt_v, 32'h1);
        chk("s4_busy_after", busy_v, 32'h0);
        chk("s4_trig_after", trig_v, 32'h0);
        chk("s4_no_done", done_v, 32'h0);
        chk("s4_cnt_held", {16'd0, pulse_cnt_s}, 32'd7);

        // 5: start+abort together in IDLE does nothing; restart mid-run ignored
        set_cfg(3, 2, 5, 3);
        abort_s = 1'b1; start_s = 1'b1;
        tick();
        abort_s = 1'b0; start_s = 1'b0;
        run_cap(5, 1'b0, -1);
        chk("s5_idle_busy", busy_v, 32'h0);
        chk("s5_idle_abt", {cfg_err_s, abt_v[30:0]}, 32'h0);
        chk("s5_idle_cnt", {16'd0, pulse_cnt_s}, 32'd7);
        set_cfg(3, 2, 5, 3);
        run_cap(20, 1'b1, 6);
        chk("s5_trig", trig_v, 32'h0000_C630);
        chk("s5_busy", busy_v, 32'h0001_FFFE);
        chk("s5_done", done_v, 32'h0001_0000);
        chk("s5_cnt", {16'd0, pulse_cnt_s}, 32'd3);

        // 6: asynchronous reset while the trigger is high
        set_cfg(0, 4, 8, 0);
        run_cap(2, 1'b1, -1);
        chk("s6_trig_hi", {31'd0, trig_s}, 32'd1);
        #2 rst_n_s = 1'b0;
        #1;
        chk("s6_async_trig", {31'd0, trig_s}, 32'd0);
        chk("s6_async_busy", {31'd0, busy_s}, 32'd0);
        @(negedge sys_clk_s); rst_n_s = 1'b1;
        run_cap(4, 1'b0, -1);
        chk("s6_post_outs", trig_v | busy_v | done_v | err_v | abt_v, 32'h0);
        chk("s6_post_cnt", {16'd0, pulse_cnt_s}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
